buzzer_player: RTL and testbench

Audio-alert sequencer for the washer front panel. It consumes one-cycle event pulses from the control logic: a key click on every accepted key press, and an alarm when the wash cycle completes. It plays the matching beep pattern on the piezo as a square-wave tone and mirrors "tone sounding" on the panel buzzer LED. It is the consuming end of the beep-request path: control logic raises events, this block times and drives the output.

---
 rtl/buzzer_pkg.sv | 27 ++
 rtl/buzzer_player_tone_gen.sv | 52 +++++
 rtl/buzzer_player.sv | 139 +++++++++++++
 tb/tb_buzzer_player.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer alert sequencer.
//   state_t : pattern FSM states (IDLE, ON, OFF)
//   kind_t  : which pattern is playing (CLICK, ALARM)
//   *_UNITS : phase lengths expressed in beep units
//   cnt_width() : counter width that stays at least one bit for tiny ranges
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  typedef enum logic {
    CLICK = 1'b0,
    ALARM = 1'b1
  } kind_t;

  localparam int CLICK_ON_UNITS  = 1;
  localparam int ALARM_ON_UNITS  = 2;
  localparam int ALARM_OFF_UNITS = 1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buzzer_player_tone_gen.sv
// Square-wave tone divider for the piezo.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : restart the wave high with the divider at zero
//   en         : advance the divider by one cycle
//   wave_nxt   : value the wave takes after this edge (look-ahead, so the
//                caller can register the gated buzzer without a cycle of lag)
module tone_gen
  import buzzer_pkg::*;
#(
  parameter int TONE_HALF = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wave_nxt
);

  localparam int TW = cnt_width(TONE_HALF);
  localparam logic [TW-1:0] HALF_LAST = TW'(TONE_HALF - 1);

  logic [TW-1:0] div_cnt;
  logic [TW-1:0] div_cnt_nxt;
  logic          wave;

  always_comb begin
    div_cnt_nxt = div_cnt;
    wave_nxt    = wave;
    if (clr) begin
      div_cnt_nxt = '0;
      wave_nxt    = 1'b1;
    end else if (en) begin
      if (div_cnt == HALF_LAST) begin
        div_cnt_nxt = '0;
        wave_nxt    = ~wave;
      end else begin
        div_cnt_nxt = div_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      wave    <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      wave    <= wave_nxt;
    end
  end

endmodule

// File: rtl/buzzer_player.sv
// Audio-alert sequencer: plays a one-beep click on key_evt and a multi-beep
// alarm on finish_evt, driving the piezo with a square-wave tone.
//   clk, reset : system clock, synchronous active-high reset
//   key_evt    : one-cycle pulse, key press accepted
//   finish_evt : one-cycle pulse, wash program finished
//   mute       : level, silences buzzer only
//   buzzer     : registered square-wave piezo drive
//   buzzer_led : registered, high during every beep ON phase
//   busy       : registered, high while a pattern is in progress
module buzzer_player
  import buzzer_pkg::*;
#(
  parameter int TONE_HALF   = 25000,
  parameter int UNIT        = 5000000,
  parameter int ALARM_BEEPS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic key_evt,
  input  logic finish_evt,
  input  logic mute,
  output logic buzzer,
  output logic buzzer_led,
  output logic busy
);

  localparam int UW = cnt_width(2 * UNIT);
  localparam int BW = cnt_width(ALARM_BEEPS);

  localparam logic [UW-1:0] CLICK_ON_LAST  = UW'(CLICK_ON_UNITS * UNIT - 1);
  localparam logic [UW-1:0] ALARM_ON_LAST  = UW'(ALARM_ON_UNITS * UNIT - 1);
  localparam logic [UW-1:0] ALARM_OFF_LAST = UW'(ALARM_OFF_UNITS * UNIT - 1);
  localparam logic [BW-1:0] BEEP_LAST      = BW'(ALARM_BEEPS - 1);

  state_t        state, state_nxt;
  kind_t         kind, kind_nxt;
  logic [UW-1:0] unit_cnt, unit_cnt_nxt;
  logic [BW-1:0] beep_cnt, beep_cnt_nxt;
  logic          tone_clr;
  logic          tone_en;
  logic          tone_nxt;
  logic          on_nxt;

  // Next-state logic: events first (finish over key), then phase timing.
  always_comb begin
    state_nxt    = state;
    kind_nxt     = kind;
    unit_cnt_nxt = unit_cnt + UW'(1);
    beep_cnt_nxt = beep_cnt;
    tone_clr     = 1'b0;

    if (finish_evt) begin
      state_nxt    = ON;
      kind_nxt     = ALARM;
      unit_cnt_nxt = '0;
      beep_cnt_nxt = '0;
      tone_clr     = 1'b1;
    end else if (key_evt && (state == IDLE || kind == CLICK)) begin
      // Keys retrigger a click but never disturb a running alarm.
      state_nxt    = ON;
      kind_nxt     = CLICK;
      unit_cnt_nxt = '0;
      beep_cnt_nxt = '0;
      tone_clr     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          unit_cnt_nxt = '0;
        end
        ON: begin
          if (kind == CLICK) begin
            if (unit_cnt == CLICK_ON_LAST) begin
              state_nxt    = IDLE;
              unit_cnt_nxt = '0;
            end
          end else if (unit_cnt == ALARM_ON_LAST) begin
            unit_cnt_nxt = '0;
            if (beep_cnt == BEEP_LAST) begin
              // Last beep has no trailing OFF gap.
              state_nxt    = IDLE;
              beep_cnt_nxt = '0;
            end else begin
              state_nxt    = OFF;
              beep_cnt_nxt = beep_cnt + BW'(1);
            end
          end
        end
        OFF: begin
          if (unit_cnt == ALARM_OFF_LAST) begin
            state_nxt    = ON;
            unit_cnt_nxt = '0;
            tone_clr     = 1'b1;
          end
        end
        default: begin
          state_nxt    = IDLE;
          unit_cnt_nxt = '0;
          beep_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign on_nxt  = (state_nxt == ON);
  assign tone_en = on_nxt;

  tone_gen #(
    .TONE_HALF (TONE_HALF)
  ) u_tone_gen (
    .clk      (clk),
    .reset    (reset),
    .clr      (tone_clr),
    .en       (tone_en),
    .wave_nxt (tone_nxt)
  );

  // State, counters and registered outputs (decoded from the next state so
  // outputs line up with the state they describe).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      kind       <= CLICK;
      unit_cnt   <= '0;
      beep_cnt   <= '0;
      buzzer     <= 1'b0;
      buzzer_led <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      kind       <= kind_nxt;
      unit_cnt   <= unit_cnt_nxt;
      beep_cnt   <= beep_cnt_nxt;
      buzzer     <= on_nxt & tone_nxt & ~mute;
      buzzer_led <= on_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_buzzer_player.sv
module tb_buzzer_player;

  localparam int TH = 2;
  localparam int U  = 8;
  localparam int AB = 3;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_evt = 1'b0;
  logic finish_evt = 1'b0;
  logic mute = 1'b0;
  logic buzzer, buzzer_led, busy;

  int checks = 0;
  int failures = 0;

  buzzer_player #(
    .TONE_HALF   (TH),
    .UNIT        (U),
    .ALARM_BEEPS (AB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_evt    (key_evt),
    .finish_evt (finish_evt),
    .mute       (mute),
    .buzzer     (buzzer),
    .buzzer_led (buzzer_led),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Bit c of an input vector is driven during cycle c (sampled at edge c);
  // bit c of an expected vector is the output seen during cycle c.
  typedef struct {
    string        name;
    int           len;
    logic [127:0] key;
    logic [127:0] fin;
    logic [127:0] mu;
    logic [127:0] rst;
    logic [127:0] led;
    logic [127:0] bsy;
    logic [127:0] buz;
  } vec_t;

  vec_t vt [NV];

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] bit1(input int b);
    return rng(b, b);
  endfunction

  // Tone seen over an ON phase of n cycles starting at cycle s: high for
  // TH cycles, low for TH cycles, starting high.
  function automatic logic [127:0] tone(input int s, input int n);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < n; i++)
      if (((i / TH) % 2) == 0) m[s + i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input string nm, input int len);
    vec_t v;
    v.name = nm;
    v.len  = len;
    v.key  = '0;
    v.fin  = '0;
    v.mu   = '0;
    v.rst  = '0;
    v.led  = '0;
    v.bsy  = '0;
    v.buz  = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input int c, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", nm, c, act, exp);
    end
  endtask

  task automatic do_reset();
    key_evt    = 1'b0;
    finish_evt = 1'b0;
    mute       = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run(input vec_t v);
    do_reset();
    for (int c = 0; c < v.len; c++) begin
      chk({v.name, ".led"},    c, buzzer_led, v.led[c]);
      chk({v.name, ".busy"},   c, busy,       v.bsy[c]);
      chk({v.name, ".buzzer"}, c, buzzer,     v.buz[c]);
      key_evt    = v.key[c];
      finish_evt = v.fin[c];
      mute       = v.mu[c];
      reset      = v.rst[c];
      @(posedge clk);
      #1;
    end
    key_evt    = 1'b0;
    finish_evt = 1'b0;
    mute       = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    // Single click.
    vt[0] = mk("click", 22);
    vt[0].key = bit1(10);
    vt[0].led = rng(11, 18);
    vt[0].bsy = rng(11, 18);
    vt[0].buz = tone(11, 8);

    // Full alarm.
    vt[1] = mk("alarm", 68);
    vt[1].fin = bit1(0);
    vt[1].led = rng(1, 16) | rng(25, 40) | rng(49, 64);
    vt[1].bsy = rng(1, 64);
    vt[1].buz = tone(1, 16) | tone(25, 16) | tone(49, 16);

    // Alarm preempts a click; a later key is ignored.
    vt[2] = mk("preempt", 72);
    vt[2].key = bit1(0) | bit1(30);
    vt[2].fin = bit1(4);
    vt[2].led = rng(1, 20) | rng(29, 44) | rng(53, 68);
    vt[2].bsy = rng(1, 68);
    vt[2].buz = tone(1, 4) | tone(5, 16) | tone(29, 16) | tone(53, 16);

    // Click retrigger mid-ON.
    vt[3] = mk("retrigger", 16);
    vt[3].key = bit1(0) | bit1(5);
    vt[3].led = rng(1, 13);
    vt[3].bsy = rng(1, 13);
    vt[3].buz = tone(1, 5) | tone(6, 8);

    // Simultaneous key and finish: alarm wins.
    vt[4] = mk("simul", 68);
    vt[4].key = bit1(0);
    vt[4].fin = bit1(0);
    vt[4].led = vt[1].led;
    vt[4].bsy = vt[1].bsy;
    vt[4].buz = vt[1].buz;

    // Reset inside an alarm, then finish together with reset.
    vt[5] = mk("reset_alarm", 30);
    vt[5].fin = bit1(0) | bit1(25);
    vt[5].rst = bit1(20) | bit1(25);
    vt[5].led = rng(1, 16);
    vt[5].bsy = rng(1, 20);
    vt[5].buz = tone(1, 16);

    // Reset during a click ON phase.
    vt[6] = mk("reset_click", 10);
    vt[6].key = bit1(0);
    vt[6].rst = bit1(5);
    vt[6].led = rng(1, 5);
    vt[6].bsy = rng(1, 5);
    vt[6].buz = tone(1, 5);

    // Mute held through a click.
    vt[7] = mk("mute_hold", 13);
    vt[7].key = bit1(1);
    vt[7].mu  = rng(0, 12);
    vt[7].led = rng(2, 9);
    vt[7].bsy = rng(2, 9);

    // Mute released mid-ON: divider phase kept.
    vt[8] = mk("mute_release", 12);
    vt[8].key = bit1(0);
    vt[8].mu  = rng(0, 3);
    vt[8].led = rng(1, 8);
    vt[8].bsy = rng(1, 8);
    vt[8].buz = tone(1, 8) & rng(5, 8);

    // Key in the last ON cycle restarts with no gap.
    vt[9] = mk("last_cycle", 30);
    vt[9].key = bit1(10) | bit1(18);
    vt[9].led = rng(11, 26);
    vt[9].bsy = rng(11, 26);
    vt[9].buz = tone(11, 8) | tone(19, 8);

    for (int i = 0; i < NV; i++) run(vt[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
